// File: rtl/axis_chk_pkg.sv
// axis_chk_pkg: error-bit layout and helpers shared by the AXI-Stream checker.
package axis_chk_pkg;
  localparam int ERR_WIDTH          = 5;
  localparam int ERR_VALID_DROP     = 0;
  localparam int ERR_PAYLOAD_CHANGE = 1;
  localparam int ERR_STRB_NO_KEEP   = 2;
  localparam int ERR_STALL_TIMEOUT  = 3;
  localparam int ERR_ID_SWITCH      = 4;
  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n += 8'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/axi_stream_channel_checker.sv
// axi_stream_channel_checker: protocol checks and saturating traffic counters for one stream.
module axi_stream_channel_checker
  import axis_chk_pkg::*;
#(
  parameter int BYTE_WIDTH       = 4,
  parameter int ID_WIDTH         = 0,
  parameter int DEST_WIDTH       = 0,
  parameter int USER_WIDTH       = 0,
  parameter int COUNT_WIDTH      = 32,
  parameter int MAX_STALL_CYCLES = 0,
  parameter int ALLOW_INTERLEAVE = 1,
  localparam int IW = ID_WIDTH > 0 ? ID_WIDTH : 1,
  localparam int DW = DEST_WIDTH > 0 ? DEST_WIDTH : 1,
  localparam int UW = USER_WIDTH > 0 ? USER_WIDTH : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    tvalid,
  input  logic                    tready,
  input  logic [8*BYTE_WIDTH-1:0] tdata,
  input  logic [BYTE_WIDTH-1:0]   tstrb,
  input  logic [BYTE_WIDTH-1:0]   tkeep,
  input  logic                    tlast,
  input  logic [IW-1:0]           tid,
  input  logic [DW-1:0]           tdest,
  input  logic [UW-1:0]           tuser,
  output logic [ERR_WIDTH-1:0]    err_flags,
  output logic                    err_pulse,
  output logic [COUNT_WIDTH-1:0]  beat_count,
  output logic [COUNT_WIDTH-1:0]  packet_count,
  output logic [COUNT_WIDTH-1:0]  byte_count
);
  localparam int SW = MAX_STALL_CYCLES > 0 ? $clog2(MAX_STALL_CYCLES + 1) : 1;
  logic armed, prev_valid, prev_ready, prev_last, in_packet;
  logic [8*BYTE_WIDTH-1:0] prev_data;
  logic [BYTE_WIDTH-1:0] prev_strb, prev_keep, data_diff;
  logic [IW-1:0] prev_id, pkt_id;
  logic [DW-1:0] prev_dest, pkt_dest;
  logic [UW-1:0] prev_user;
  logic [SW-1:0] stall_cnt, stall_nxt;
  logic [ERR_WIDTH-1:0] viol;
  logic hs, stalled, held, side_change, id_change;
  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a, input logic [7:0] b);
    logic [COUNT_WIDTH+8:0] s;
    s = (COUNT_WIDTH+9)'(a) + (COUNT_WIDTH+9)'(b);
    return (s >> COUNT_WIDTH) != '0 ? '1 : s[COUNT_WIDTH-1:0];
  endfunction
  always_comb begin
    hs = tvalid && tready;
    stalled = tvalid && !tready;
    held = armed && prev_valid && !prev_ready;
    data_diff = '0;
    for (int i = 0; i < BYTE_WIDTH; i++)
      data_diff[i] = prev_keep[i] && prev_strb[i] && (tdata[8*i +: 8] != prev_data[8*i +: 8]);
    side_change = (ID_WIDTH > 0 && tid != prev_id) || (DEST_WIDTH > 0 && tdest != prev_dest) ||
                  (USER_WIDTH > 0 && tuser != prev_user);
    id_change = (ID_WIDTH > 0 && tid != pkt_id) || (DEST_WIDTH > 0 && tdest != pkt_dest);
    stall_nxt = !stalled ? '0 : (int'(stall_cnt) >= MAX_STALL_CYCLES ? stall_cnt : stall_cnt + 1'b1);
    viol = '0;
    viol[ERR_VALID_DROP] = held && !tvalid;
    viol[ERR_PAYLOAD_CHANGE] = held && tvalid && (tkeep != prev_keep || tstrb != prev_strb ||
                               tlast != prev_last || side_change || |data_diff);
    viol[ERR_STRB_NO_KEEP] = tvalid && |(tstrb & ~tkeep);
    viol[ERR_STALL_TIMEOUT] = MAX_STALL_CYCLES > 0 && stalled && int'(stall_cnt) == MAX_STALL_CYCLES - 1;
    viol[ERR_ID_SWITCH] = ALLOW_INTERLEAVE == 0 && armed && hs && in_packet && id_change;
  end
  // History keeps tracking through clear so checks stay live across it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      armed <= 1'b0;
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
      prev_last <= 1'b0;
      prev_data <= '0;
      prev_strb <= '0;
      prev_keep <= '0;
      prev_id <= '0;
      prev_dest <= '0;
      prev_user <= '0;
      in_packet <= 1'b0;
      pkt_id <= '0;
      pkt_dest <= '0;
      stall_cnt <= '0;
      err_flags <= '0;
      err_pulse <= 1'b0;
      beat_count <= '0;
      packet_count <= '0;
      byte_count <= '0;
    end else begin
      armed <= 1'b1;
      prev_valid <= tvalid;
      prev_ready <= tready;
      prev_last <= tlast;
      prev_data <= tdata;
      prev_strb <= tstrb;
      prev_keep <= tkeep;
      prev_id <= tid;
      prev_dest <= tdest;
      prev_user <= tuser;
      if (clear) begin
        in_packet <= 1'b0;
        stall_cnt <= '0;
        err_flags <= '0;
        err_pulse <= 1'b0;
        beat_count <= '0;
        packet_count <= '0;
        byte_count <= '0;
      end else begin
        if (hs) begin
          in_packet <= !tlast;
          if (!in_packet) begin
            pkt_id <= tid;
            pkt_dest <= tdest;
          end
        end
        stall_cnt <= stall_nxt;
        err_flags <= err_flags | viol;
        err_pulse <= |viol;
        beat_count <= sat_add(beat_count, 8'(hs));
        packet_count <= sat_add(packet_count, 8'(hs && tlast));
        byte_count <= sat_add(byte_count, hs ? popcount(64'(tkeep)) : 8'd0);
      end
    end
endmodule

// File: rtl/axi_stream_multi_checker.sv
// axi_stream_multi_checker: passive protocol checker and traffic counter over several AXI-Stream taps.
module axi_stream_multi_checker
  import axis_chk_pkg::*;
#(
  parameter int NUM_CHANNELS     = 1,
  parameter int BYTE_WIDTH       = 4,
  parameter int ID_WIDTH         = 0,
  parameter int DEST_WIDTH       = 0,
  parameter int USER_WIDTH       = 0,
  parameter int COUNT_WIDTH      = 32,
  parameter int MAX_STALL_CYCLES = 0,
  parameter int ALLOW_INTERLEAVE = 1,
  localparam int IW = ID_WIDTH > 0 ? ID_WIDTH : 1,
  localparam int DW = DEST_WIDTH > 0 ? DEST_WIDTH : 1,
  localparam int UW = USER_WIDTH > 0 ? USER_WIDTH : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic [NUM_CHANNELS-1:0]              tvalid,
  input  logic [NUM_CHANNELS-1:0]              tready,
  input  logic [NUM_CHANNELS*8*BYTE_WIDTH-1:0] tdata,
  input  logic [NUM_CHANNELS*BYTE_WIDTH-1:0]   tstrb,
  input  logic [NUM_CHANNELS*BYTE_WIDTH-1:0]   tkeep,
  input  logic [NUM_CHANNELS-1:0]              tlast,
  input  logic [NUM_CHANNELS*IW-1:0]           tid,
  input  logic [NUM_CHANNELS*DW-1:0]           tdest,
  input  logic [NUM_CHANNELS*UW-1:0]           tuser,
  output logic [NUM_CHANNELS*ERR_WIDTH-1:0]    err_flags,
  output logic                                 err_any,
  output logic [NUM_CHANNELS-1:0]              err_pulse,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0]  beat_count,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0]  packet_count,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0]  byte_count
);
  genvar c;
  for (c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    axi_stream_channel_checker #(
      .BYTE_WIDTH(BYTE_WIDTH), .ID_WIDTH(ID_WIDTH), .DEST_WIDTH(DEST_WIDTH), .USER_WIDTH(USER_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH), .MAX_STALL_CYCLES(MAX_STALL_CYCLES), .ALLOW_INTERLEAVE(ALLOW_INTERLEAVE)
    ) u_chk (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .tvalid(tvalid[c]),
      .tready(tready[c]),
      .tdata(tdata[c*8*BYTE_WIDTH +: 8*BYTE_WIDTH]),
      .tstrb(tstrb[c*BYTE_WIDTH +: BYTE_WIDTH]),
      .tkeep(tkeep[c*BYTE_WIDTH +: BYTE_WIDTH]),
      .tlast(tlast[c]),
      .tid(tid[c*IW +: IW]),
      .tdest(tdest[c*DW +: DW]),
      .tuser(tuser[c*UW +: UW]),
      .err_flags(err_flags[c*ERR_WIDTH +: ERR_WIDTH]),
      .err_pulse(err_pulse[c]),
      .beat_count(beat_count[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .packet_count(packet_count[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .byte_count(byte_count[c*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end
  assign err_any = |err_flags;
endmodule

// File: tb/tb_axi_stream_multi_checker.sv
// tb_axi_stream_multi_checker: directed and random traffic on two checker variants against a beat-level model.
module tb_axi_stream_multi_checker;
  localparam int NC = 2, CW = 8, SAT = 255, STALL = 8;
  typedef struct packed {
    logic v, r, last;
    logic [31:0] d;
    logic [3:0] k, s, id;
    logic [1:0] dst, usr;
  } beat_t;
  logic clk = 0, reset = 0, clr = 0;
  beat_t cur[NC], prev[NC];
  logic [NC-1:0] tvalid, tready, tlast, pulse0, pulse1;
  logic [NC*32-1:0] tdata;
  logic [NC*4-1:0] tstrb, tkeep, tid;
  logic [NC*2-1:0] tdest, tuser;
  logic [NC*5-1:0] flags0, flags1;
  logic any0, any1;
  logic [NC*CW-1:0] beat0, beat1, pkt0, pkt1, byte0, byte1;
  int compared = 0, mismatched = 0;
  string phase = "reset";
  bit m_armed, m_inpkt[NC], e_pulse[2][NC], slow[NC];
  int m_stall[NC], e_beat[NC], e_pkt[NC], e_byte[NC];
  logic [3:0] m_pid[NC];
  logic [1:0] m_pdest[NC];
  logic [4:0] e_flags[2][NC];
  always #5 clk = ~clk;
  always_comb begin
    tvalid = '0; tready = '0; tlast = '0; tdata = '0; tkeep = '0; tstrb = '0; tid = '0; tdest = '0; tuser = '0;
    for (int c = 0; c < NC; c++) begin
      tvalid[c] = cur[c].v; tready[c] = cur[c].r; tlast[c] = cur[c].last;
      tdata[c*32 +: 32] = cur[c].d; tkeep[c*4 +: 4] = cur[c].k; tstrb[c*4 +: 4] = cur[c].s;
      tid[c*4 +: 4] = cur[c].id; tdest[c*2 +: 2] = cur[c].dst; tuser[c*2 +: 2] = cur[c].usr;
    end
  end
  axi_stream_multi_checker #(.NUM_CHANNELS(NC), .BYTE_WIDTH(4), .ID_WIDTH(4), .DEST_WIDTH(2), .USER_WIDTH(2),
    .COUNT_WIDTH(CW), .MAX_STALL_CYCLES(STALL), .ALLOW_INTERLEAVE(0)) u_dut0 (
    .clk(clk), .reset(reset), .clear(clr), .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb),
    .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser), .err_flags(flags0), .err_any(any0),
    .err_pulse(pulse0), .beat_count(beat0), .packet_count(pkt0), .byte_count(byte0));
  axi_stream_multi_checker #(.NUM_CHANNELS(NC), .BYTE_WIDTH(4), .ID_WIDTH(4), .DEST_WIDTH(2), .USER_WIDTH(2),
    .COUNT_WIDTH(CW), .MAX_STALL_CYCLES(0), .ALLOW_INTERLEAVE(1)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clr), .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb),
    .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser), .err_flags(flags1), .err_any(any1),
    .err_pulse(pulse1), .beat_count(beat1), .packet_count(pkt1), .byte_count(byte1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int x);
    return x > SAT ? SAT : x;
  endfunction

  task automatic model_reset();
    m_armed = 0;
    for (int c = 0; c < NC; c++) begin
      prev[c] = '0; m_stall[c] = 0; m_inpkt[c] = 0; m_pid[c] = '0; m_pdest[c] = '0;
      e_beat[c] = 0; e_pkt[c] = 0; e_byte[c] = 0;
      for (int k = 0; k < 2; k++) begin e_flags[k][c] = '0; e_pulse[k][c] = 0; end
    end
  endtask

  // One clock edge of the spec rules: variant 0 has an 8-cycle timeout and no interleave, variant 1 neither.
  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      beat_t b = cur[c], p = prev[c];
      bit hs = b.v && b.r, held = m_armed && p.v && !p.r, dchg = 0;
      logic [4:0] vv[2];
      for (int i = 0; i < 4; i++) if (p.k[i] && p.s[i] && b.d[8*i +: 8] != p.d[8*i +: 8]) dchg = 1;
      vv[0] = '0;
      vv[0][0] = held && !b.v;
      vv[0][1] = held && b.v && (dchg || b.k != p.k || b.s != p.s || b.last != p.last ||
                 b.id != p.id || b.dst != p.dst || b.usr != p.usr);
      vv[0][2] = b.v && ((b.s & ~b.k) != 4'd0);
      vv[1] = vv[0];
      vv[0][3] = b.v && !b.r && m_stall[c] == STALL - 1;
      vv[0][4] = m_armed && hs && m_inpkt[c] && (b.id != m_pid[c] || b.dst != m_pdest[c]);
      if (clr) begin
        m_stall[c] = 0; m_inpkt[c] = 0; e_beat[c] = 0; e_pkt[c] = 0; e_byte[c] = 0;
        for (int k = 0; k < 2; k++) begin e_flags[k][c] = '0; e_pulse[k][c] = 0; end
      end else begin
        for (int k = 0; k < 2; k++) begin e_flags[k][c] |= vv[k]; e_pulse[k][c] = |vv[k]; end
        e_beat[c] = sat(e_beat[c] + int'(hs));
        e_pkt[c] = sat(e_pkt[c] + int'(hs && b.last));
        e_byte[c] = sat(e_byte[c] + (hs ? $countones(b.k) : 0));
        m_stall[c] = (b.v && !b.r) ? (m_stall[c] < STALL ? m_stall[c] + 1 : STALL) : 0;
        if (hs) begin
          if (!m_inpkt[c]) begin m_pid[c] = b.id; m_pdest[c] = b.dst; end
          m_inpkt[c] = !b.last;
        end
      end
      prev[c] = b;
    end
    m_armed = 1;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [NC*5-1:0] gf = k ? flags1 : flags0;
      logic [NC-1:0] gp = k ? pulse1 : pulse0;
      logic [NC*CW-1:0] gb = k ? beat1 : beat0, gk = k ? pkt1 : pkt0, gy = k ? byte1 : byte0;
      logic ef_any = 0;
      for (int c = 0; c < NC; c++) begin
        check($sformatf("%s dut%0d ch%0d flags", phase, k, c), 32'(gf[c*5 +: 5]), 32'(e_flags[k][c]));
        check($sformatf("%s dut%0d ch%0d pulse", phase, k, c), 32'(gp[c]), 32'(e_pulse[k][c]));
        check($sformatf("%s dut%0d ch%0d beats", phase, k, c), 32'(gb[c*CW +: CW]), e_beat[c]);
        check($sformatf("%s dut%0d ch%0d packets", phase, k, c), 32'(gk[c*CW +: CW]), e_pkt[c]);
        check($sformatf("%s dut%0d ch%0d bytes", phase, k, c), 32'(gy[c*CW +: CW]), e_byte[c]);
        ef_any |= |e_flags[k][c];
      end
      check($sformatf("%s dut%0d err_any", phase, k), 32'(k ? any1 : any0), 32'(ef_any));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1;
    #2;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  function automatic beat_t mk(input logic v, r, last, input logic [31:0] d, input logic [3:0] k, s, id);
    beat_t b = '0;
    b.v = v; b.r = r; b.last = last; b.d = d; b.k = k; b.s = s; b.id = id;
    return b;
  endfunction

  task automatic idle();
    for (int c = 0; c < NC; c++) cur[c] = '0;
  endtask

  task automatic clear_all();
    idle(); clr = 1; tick(); clr = 0; tick();
  endtask

  initial begin
    idle();
    #1;
    do_reset();
    check("reset beats", 32'(beat0), 0);
    check("reset flags", 32'(flags0), 0);
    phase = "clean";
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) begin cur[0] = mk(1, 1, i == 3, $urandom, 4'hF, 4'hF, 2); tick(); end
    idle(); tick();
    check("clean beat_count", 32'(beat0[CW-1:0]), 12);
    check("clean packet_count", 32'(pkt0[CW-1:0]), 3);
    check("clean byte_count", 32'(byte0[CW-1:0]), 48);
    check("clean err_flags", 32'(flags0), 0);
    phase = "valid_drop";
    cur[0] = mk(1, 0, 0, 32'h1234, 4'hF, 4'hF, 2); tick();
    idle(); tick();
    check("valid_drop flag", 32'(flags0[0]), 1);
    check("valid_drop pulse", 32'(pulse0[0]), 1);
    tick();
    check("valid_drop pulse ends", 32'(pulse0[0]), 0);
    check("valid_drop sticky", 32'(flags1[0]), 1);
    clear_all();
    phase = "payload";
    cur[0] = mk(1, 0, 0, 32'h11223344, 4'h1, 4'h1, 2); tick();
    cur[0].d = 32'h11225544; tick();
    check("payload masked byte", 32'(flags0[4:0]), 0);
    cur[0].d = 32'h11225599; tick();
    check("payload live byte", 32'(flags0[1]), 1);
    cur[0].r = 1; tick();
    idle(); tick();
    clear_all();
    phase = "stall";
    cur[0] = mk(1, 0, 0, 32'hCAFE, 4'h3, 4'h3, 2);
    repeat (7) tick();
    check("stall 7 cycles", 32'(flags0[3]), 0);
    tick();
    check("stall 8th cycle", 32'(flags0[3]), 1);
    check("stall disabled variant", 32'(flags1[3]), 0);
    cur[0].r = 1; tick();
    idle(); tick();
    clear_all();
    phase = "id_switch";
    cur[0] = mk(1, 1, 0, 32'h1, 4'hF, 4'hF, 2); tick();
    cur[0] = mk(1, 1, 0, 32'h2, 4'hF, 4'hF, 5); tick();
    check("id_switch no interleave", 32'(flags0[4]), 1);
    check("id_switch interleave ok", 32'(flags1[4:0]), 0);
    cur[0] = mk(1, 1, 1, 32'h3, 4'hF, 4'hF, 5); tick();
    clear_all();
    phase = "saturate";
    cur[0] = mk(1, 1, 1, 32'h0, 4'hF, 4'hF, 2);
    repeat (260) tick();
    check("saturate beats", 32'(beat0[CW-1:0]), SAT);
    check("saturate bytes", 32'(byte0[CW-1:0]), SAT);
    clr = 1; tick(); clr = 0;
    check("clear wins beats", 32'(beat0[CW-1:0]), 0);
    check("clear wins packets", 32'(pkt0[CW-1:0]), 0);
    phase = "mid_reset";
    cur[0] = mk(1, 0, 0, 32'h5, 4'hF, 4'hF, 2);
    cur[1] = mk(1, 1, 0, 32'h6, 4'hF, 4'hF, 3);
    repeat (3) tick();
    do_reset();
    check("mid_reset flags", 32'(flags0), 0);
    cur[1] = mk(1, 1, 0, 32'h7, 4'hF, 4'hF, 7); tick();
    cur[1].last = 1; tick();
    repeat (9) tick();
    check("mid_reset stall restarted", 32'(flags0[3]), 1);
    idle(); tick();
    phase = "random";
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < NC; c++) begin
        beat_t b = '0;
        if ($urandom_range(63) == 0) slow[c] = !slow[c];
        if (cur[c].v && !cur[c].r && $urandom_range(9) != 0) b = cur[c];
        else begin
          b.v = $urandom_range(3) != 0;
          b.d = $urandom;
          b.k = 4'($urandom);
          b.s = $urandom_range(7) == 0 ? 4'($urandom) : b.k & 4'($urandom);
          b.id = 4'($urandom_range(3, 2));
          b.dst = 2'($urandom_range(1));
          b.usr = 2'($urandom);
          b.last = $urandom_range(3) == 0;
        end
        b.r = slow[c] ? $urandom_range(7) == 0 : $urandom_range(2) != 0;
        cur[c] = b;
      end
      clr = $urandom_range(199) == 0;
      tick();
    end
    clr = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
